// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: DIFF = A - B - BIN, one decimal digit
// per clock, least significant digit first, with decimal borrow.
// Operands are taken on a start/done handshake. The result registers keep
// their value until the next request completes.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns 1 if any nibble of the packed operand is not a decimal digit.
  function automatic logic has_bad_nibble(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One decimal digit of subtraction. Result is {borrow_out, digit}.
  function automatic logic [4:0] sub_digit(input logic [3:0] ad,
                                           input logic [3:0] bd,
                                           input logic       bw);
    logic signed [4:0] t;
    logic signed [4:0] adj;
    t = signed'({1'b0, ad}) - signed'({1'b0, bd}) - signed'({4'b0000, bw});
    if (t < 0) begin
      adj = t + 5'sd10;
      return {1'b1, adj[3:0]};
    end
    return {1'b0, t[3:0]};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             err_q, err_d;

  // Working copies of the operands and the partial result; these carry no
  // reset because nothing observes them outside RUN.
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;

  logic [4:0]       dig_res;
  int               dig_idx;

  // Next-state, digit datapath and result update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    err_d    = err_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    borrow_d = borrow_q;
    dig_idx  = int'(cnt_q);
    dig_res  = sub_digit(a_sh_q[4*dig_idx +: 4], b_sh_q[4*dig_idx +: 4], borrow_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          res_sh_d = '0;
          cnt_d    = '0;
          if (has_bad_nibble(a) || has_bad_nibble(b)) begin
            // Malformed operands skip the digit loop and report straight away.
            state_d = DONE;
            diff_d  = '0;
            bout_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        res_sh_d[4*dig_idx +: 4] = dig_res[3:0];
        borrow_d                 = dig_res[4];
        if (cnt_q == LAST_DIGIT) begin
          // Results are published only here so they stay stable during RUN.
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = res_sh_d;
          bout_d  = dig_res[4];
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and published-result registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  // Operand and partial-result working registers.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    res_sh_q <= res_sh_d;
    borrow_q <= borrow_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for the digit-serial BCD subtractor (DIGITS = 4).
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         err;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_done_cyc = -1;
  bit gap_en   = 1'b0;
  logic prev_done = 1'b0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal reference model working on integer values.
  function automatic exp_t ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t e;
    int   ai, bi_v, d;
    logic bad;
    bad  = 1'b0;
    ai   = 0;
    bi_v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
      ai   = ai * 10 + int'(av[4*i +: 4]);
      bi_v = bi_v * 10 + int'(bv[4*i +: 4]);
    end
    e = '0;
    if (bad) begin
      e.err = 1'b1;
      return e;
    end
    d = ai - bi_v - int'(bi);
    if (d < 0) begin
      d      = d + 10000;
      e.bout = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      e.diff[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issues one request from an IDLE cycle; returns on the negedge after the
  // sampling edge with start already dropped.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       input bit push);
    wait_idle();
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    if (push) sb_q.push_back(ref_sub(av, bv, bi));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Output monitor: compares every done pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check_eq("done_width", 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("diff", 32'(diff), 32'(e.diff));
          check_eq("bout", 32'(bout), 32'(e.bout));
          check_eq("err", 32'(err), 32'(e.err));
        end
        if (gap_en && last_done_cyc >= 0) check_eq("b2b_gap", 32'(cyc - last_done_cyc), 32'd6);
        last_done_cyc = cyc;
      end
      prev_done = done;
    end
  end

  initial begin
    exp_t hold;
    int   n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_bout", 32'(bout), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic subtraction with explicit latency check.
    do_op(16'h0042, 16'h0017, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("lat_early", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("lat_done", 32'(done), 32'd1);

    // Underflow wraps to ten's complement.
    do_op(16'h0000, 16'h0001, 1'b0, 1'b1);
    do_op(16'h9999, 16'h9999, 1'b1, 1'b1);

    // Invalid nibble reports one cycle after the request.
    do_op(16'h00A0, 16'h0001, 1'b0, 1'b1);
    check_eq("err_lat", 32'(done), 32'd1);
    do_op(16'h1234, 16'h0234, 1'b0, 1'b1);
    do_op(16'h0005, 16'h00F0, 1'b1, 1'b1);
    do_op(16'h5000, 16'h0001, 1'b1, 1'b1);

    // Reset two cycles into RUN aborts without a done pulse.
    do_op(16'h0042, 16'h0017, 1'b0, 1'b1);
    wait_idle();
    do_op(16'h0800, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_diff", 32'(diff), 32'd0);
    check_eq("abort_bout", 32'(bout), 32'd0);
    check_eq("abort_err", 32'(err), 32'd0);
    repeat (10) @(negedge clk);
    do_op(16'h0100, 16'h0099, 1'b0, 1'b1);

    // Start during RUN is ignored and the held result stays put.
    wait_idle();
    hold = ref_sub(16'h0100, 16'h0099, 1'b0);
    do_op(16'h7531, 16'h2468, 1'b1, 1'b1);
    a     = 16'h9000;
    b     = 16'h0001;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("hold_diff", 32'(diff), 32'(hold.diff));
    check_eq("hold_bout", 32'(bout), 32'(hold.bout));
    check_eq("mid_busy", 32'(busy), 32'd1);

    // Random back-to-back traffic.
    wait_idle();
    last_done_cyc = -1;
    gap_en        = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      do_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b1);
    end

    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    gap_en = 1'b0;
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
